// File: rtl/dual_issue_queue.sv
// dual_issue_queue: program-order FIFO taking up to two fetch entries and issuing up to two.
// Define DIQ_STALL_CNT_EN to add the saturating dq_o_single_cnt output.
`ifndef PC_WIDTH
`define PC_WIDTH 32
`endif
`ifndef IWIDTH
`define IWIDTH 32
`endif

module dual_issue_queue #(
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic                 dq_clk,
    input  logic                 dq_rst,
    input  logic                 dq_i_flush,
    input  logic                 dq_i_valid_1,
    input  logic                 dq_i_valid_2,
    input  logic [`PC_WIDTH-1:0] dq_i_pc_1,
    input  logic [`PC_WIDTH-1:0] dq_i_pc_2,
    input  logic [`IWIDTH-1:0]   dq_i_instr_1,
    input  logic [`IWIDTH-1:0]   dq_i_instr_2,
    output logic                 dq_o_ready,
    input  logic                 dq_i_stall,
    output logic                 dq_o_valid_1,
    output logic                 dq_o_valid_2,
    output logic [`PC_WIDTH-1:0] dq_o_pc_1,
    output logic [`PC_WIDTH-1:0] dq_o_pc_2,
    output logic [`IWIDTH-1:0]   dq_o_instr_1,
    output logic [`IWIDTH-1:0]   dq_o_instr_2,
    output logic                 dq_o_single,
    output logic [CW-1:0]        dq_o_count
`ifdef DIQ_STALL_CNT_EN
    ,
    output logic [15:0]          dq_o_single_cnt
`endif
);

    logic [`PC_WIDTH-1:0] pc_mem  [DEPTH];
    logic [`IWIDTH-1:0]   ins_mem [DEPTH];

    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [AW-1:0] wptr_1;
    logic [AW-1:0] rptr_1;
    logic [CW-1:0] count;
    logic [1:0]    n_push;
    logic [1:0]    n_pop;
    logic          has_1;
    logic          has_2;
    logic          blocked;

    // Destination register of an instruction; 0 means no destination.
    function automatic logic [4:0] dest_of(input logic [`IWIDTH-1:0] ins);
        logic [4:0] d;
        case (ins[31:26])
            6'h00:                      d = ins[15:11];
            6'h02, 6'h04, 6'h05, 6'h2b: d = 5'd0;
            default:                    d = ins[20:16];
        endcase
        return d;
    endfunction

    function automatic logic is_ctrl(input logic [`IWIDTH-1:0] ins);
        return ins[31:26] inside {6'h02, 6'h03, 6'h04, 6'h05};
    endfunction

    function automatic logic pair_blocked(
        input logic [`IWIDTH-1:0] old_ins,
        input logic [`IWIDTH-1:0] yng_ins
    );
        logic [4:0] d;
        d = dest_of(old_ins);
        return is_ctrl(old_ins) ||
               ((d != 5'd0) &&
                ((d == yng_ins[25:21]) || (d == yng_ins[20:16])));
    endfunction

    assign wptr_1  = wptr + AW'(1);
    assign rptr_1  = rptr + AW'(1);
    assign has_1   = count >= CW'(1);
    assign has_2   = count >= CW'(2);
    assign blocked = pair_blocked(ins_mem[rptr], ins_mem[rptr_1]);

    assign dq_o_ready   = count <= CW'(DEPTH - 2);
    assign dq_o_count   = count;
    assign dq_o_valid_1 = has_1 && !dq_i_stall;
    assign dq_o_valid_2 = has_2 && !dq_i_stall && !blocked;
    assign dq_o_single  = has_2 && !dq_i_stall && blocked;

    assign dq_o_pc_1    = dq_o_valid_1 ? pc_mem[rptr]    : '0;
    assign dq_o_instr_1 = dq_o_valid_1 ? ins_mem[rptr]   : '0;
    assign dq_o_pc_2    = dq_o_valid_2 ? pc_mem[rptr_1]  : '0;
    assign dq_o_instr_2 = dq_o_valid_2 ? ins_mem[rptr_1] : '0;

    // Slot 2 is only meaningful together with slot 1.
    always_comb begin
        n_push = 2'd0;
        if (dq_o_ready && dq_i_valid_1)
            n_push = dq_i_valid_2 ? 2'd2 : 2'd1;
    end

    assign n_pop = {1'b0, dq_o_valid_1} + {1'b0, dq_o_valid_2};

    always_ff @(posedge dq_clk) begin
        if (!dq_i_flush && (n_push != 2'd0)) begin
            pc_mem[wptr]  <= dq_i_pc_1;
            ins_mem[wptr] <= dq_i_instr_1;
            if (n_push == 2'd2) begin
                pc_mem[wptr_1]  <= dq_i_pc_2;
                ins_mem[wptr_1] <= dq_i_instr_2;
            end
        end
    end

    always_ff @(posedge dq_clk or negedge dq_rst) begin
        if (!dq_rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (dq_i_flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            wptr  <= wptr + AW'(n_push);
            rptr  <= rptr + AW'(n_pop);
            count <= count + CW'(n_push) - CW'(n_pop);
        end
    end

`ifdef DIQ_STALL_CNT_EN
    always_ff @(posedge dq_clk or negedge dq_rst) begin
        if (!dq_rst)
            dq_o_single_cnt <= '0;
        else if (dq_i_flush)
            dq_o_single_cnt <= '0;
        else if (dq_o_single && (dq_o_single_cnt != 16'hFFFF))
            dq_o_single_cnt <= dq_o_single_cnt + 16'd1;
    end
`endif

endmodule

// File: tb/tb_dual_issue_queue.sv
// Bench for dual_issue_queue: directed vector table, corner sequences, random vs queue model.
`ifndef PC_WIDTH
`define PC_WIDTH 32
`endif
`ifndef IWIDTH
`define IWIDTH 32
`endif

module tb_dual_issue_queue;

    localparam int DEPTH = 8;
    localparam int CW = $clog2(DEPTH) + 1;

    localparam logic [31:0] ADD1 = 32'h00221820;
    localparam logic [31:0] ADD2 = 32'h00853020;
    localparam logic [31:0] SUB  = 32'h00642822;
    localparam logic [31:0] BEQ  = 32'h10220003;

    logic                 dq_clk;
    logic                 dq_rst;
    logic                 dq_i_flush;
    logic                 dq_i_valid_1;
    logic                 dq_i_valid_2;
    logic [`PC_WIDTH-1:0] dq_i_pc_1;
    logic [`PC_WIDTH-1:0] dq_i_pc_2;
    logic [`IWIDTH-1:0]   dq_i_instr_1;
    logic [`IWIDTH-1:0]   dq_i_instr_2;
    logic                 dq_o_ready;
    logic                 dq_i_stall;
    logic                 dq_o_valid_1;
    logic                 dq_o_valid_2;
    logic [`PC_WIDTH-1:0] dq_o_pc_1;
    logic [`PC_WIDTH-1:0] dq_o_pc_2;
    logic [`IWIDTH-1:0]   dq_o_instr_1;
    logic [`IWIDTH-1:0]   dq_o_instr_2;
    logic                 dq_o_single;
    logic [CW-1:0]        dq_o_count;
`ifdef DIQ_STALL_CNT_EN
    logic [15:0]          dq_o_single_cnt;
`endif

    dual_issue_queue #(.DEPTH(DEPTH)) dut (
        .dq_clk       (dq_clk),
        .dq_rst       (dq_rst),
        .dq_i_flush   (dq_i_flush),
        .dq_i_valid_1 (dq_i_valid_1),
        .dq_i_valid_2 (dq_i_valid_2),
        .dq_i_pc_1    (dq_i_pc_1),
        .dq_i_pc_2    (dq_i_pc_2),
        .dq_i_instr_1 (dq_i_instr_1),
        .dq_i_instr_2 (dq_i_instr_2),
        .dq_o_ready   (dq_o_ready),
        .dq_i_stall   (dq_i_stall),
        .dq_o_valid_1 (dq_o_valid_1),
        .dq_o_valid_2 (dq_o_valid_2),
        .dq_o_pc_1    (dq_o_pc_1),
        .dq_o_pc_2    (dq_o_pc_2),
        .dq_o_instr_1 (dq_o_instr_1),
        .dq_o_instr_2 (dq_o_instr_2),
        .dq_o_single  (dq_o_single),
        .dq_o_count   (dq_o_count)
`ifdef DIQ_STALL_CNT_EN
        ,
        .dq_o_single_cnt (dq_o_single_cnt)
`endif
    );

    initial dq_clk = 1'b0;
    always #5 dq_clk = ~dq_clk;

    typedef struct packed {
        logic [`PC_WIDTH-1:0] pc;
        logic [`IWIDTH-1:0]   ins;
    } ent_t;

    typedef struct {
        logic                 fl;
        logic                 v1;
        logic                 v2;
        logic                 st;
        logic [`PC_WIDTH-1:0] pc;
        logic [31:0]          i1;
        logic [31:0]          i2;
        logic                 ev1;
        logic                 ev2;
        logic                 es;
        int                   ec;
        logic [31:0]          eo1;
    } vec_t;

    int checks = 0;
    int errors = 0;

    ent_t q[$];
    int   mcnt = 0;
    bit   m_ready;
    bit   m_v1;
    bit   m_v2;
    bit   m_single;
    int   m_pop;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [4:0] m_dest(input logic [31:0] a);
        if (a[31:26] == 6'h00) return a[15:11];
        if (a[31:26] inside {6'h02, 6'h04, 6'h05, 6'h2b}) return 5'd0;
        return a[20:16];
    endfunction

    function automatic bit m_block(input logic [31:0] a, input logic [31:0] b);
        logic [4:0] d;
        int op;
        d = m_dest(a);
        op = int'(a[31:26]);
        if (op >= 2 && op <= 5) return 1'b1;
        return (d != 5'd0) && (d == b[25:21] || d == b[20:16]);
    endfunction

    task automatic drive(input logic fl, input logic a, input logic b,
                         input logic st, input logic [`PC_WIDTH-1:0] p,
                         input logic [`IWIDTH-1:0] x,
                         input logic [`IWIDTH-1:0] y);
        @(negedge dq_clk);
        dq_i_flush   = fl;
        dq_i_valid_1 = a;
        dq_i_valid_2 = a & b;
        dq_i_stall   = st;
        dq_i_pc_1    = p;
        dq_i_pc_2    = p + `PC_WIDTH'(4);
        dq_i_instr_1 = x;
        dq_i_instr_2 = y;
        #1;
    endtask

    task automatic model_check();
        int   n;
        ent_t h0;
        ent_t h1;
        bit   blk;
        n  = q.size();
        h0 = '0;
        h1 = '0;
        if (n >= 1) h0 = q[0];
        if (n >= 2) h1 = q[1];
        blk      = (n >= 2) && m_block(h0.ins[31:0], h1.ins[31:0]);
        m_ready  = (DEPTH - n) >= 2;
        m_v1     = (n >= 1) && !dq_i_stall;
        m_v2     = (n >= 2) && !dq_i_stall && !blk;
        m_single = (n >= 2) && !dq_i_stall && blk;
        m_pop    = int'(m_v1) + int'(m_v2);
        chk("count", 64'(dq_o_count), 64'(n));
        chk("ready", 64'(dq_o_ready), 64'(m_ready));
        chk("valid_1", 64'(dq_o_valid_1), 64'(m_v1));
        chk("valid_2", 64'(dq_o_valid_2), 64'(m_v2));
        chk("single", 64'(dq_o_single), 64'(m_single));
        chk("pc_1", 64'(dq_o_pc_1), m_v1 ? 64'(h0.pc) : 64'd0);
        chk("instr_1", 64'(dq_o_instr_1), m_v1 ? 64'(h0.ins) : 64'd0);
        chk("pc_2", 64'(dq_o_pc_2), m_v2 ? 64'(h1.pc) : 64'd0);
        chk("instr_2", 64'(dq_o_instr_2), m_v2 ? 64'(h1.ins) : 64'd0);
`ifdef DIQ_STALL_CNT_EN
        chk("single_cnt", 64'(dq_o_single_cnt), 64'(mcnt));
`endif
    endtask

    task automatic tick();
        ent_t e;
        @(posedge dq_clk);
        if (dq_i_flush) begin
            q.delete();
            mcnt = 0;
        end else begin
            if (m_single && mcnt != 16'hFFFF) mcnt++;
            for (int k = 0; k < m_pop; k++) void'(q.pop_front());
            if (m_ready && dq_i_valid_1) begin
                e.pc  = dq_i_pc_1;
                e.ins = dq_i_instr_1;
                q.push_back(e);
                if (dq_i_valid_2) begin
                    e.pc  = dq_i_pc_2;
                    e.ins = dq_i_instr_2;
                    q.push_back(e);
                end
            end
        end
    endtask

    task automatic step(input logic fl, input logic a, input logic b,
                        input logic st, input logic [`PC_WIDTH-1:0] p,
                        input logic [`IWIDTH-1:0] x,
                        input logic [`IWIDTH-1:0] y);
        drive(fl, a, b, st, p, x, y);
        model_check();
        tick();
    endtask

    function automatic logic [31:0] sw_ins(input int k);
        return {6'h2b, 5'(k), 5'(k + 1), 16'(k)};
    endfunction

    function automatic logic [31:0] rnd_ins();
        logic [5:0] ops [8];
        ops = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h2b, 6'h08, 6'h23};
        return {ops[$urandom_range(7)], 5'($urandom_range(3)),
                5'($urandom_range(3)), 5'($urandom_range(3)),
                11'($urandom)};
    endfunction

    vec_t tbl [12];

    initial begin
        tbl[0]  = '{0, 1, 1, 0, 0,  ADD1, ADD2, 0, 0, 0, 0, 0};
        tbl[1]  = '{0, 0, 0, 0, 0,  0,    0,    1, 1, 0, 2, ADD1};
        tbl[2]  = '{0, 1, 1, 0, 8,  ADD1, SUB,  0, 0, 0, 0, 0};
        tbl[3]  = '{0, 0, 0, 0, 0,  0,    0,    1, 0, 1, 2, ADD1};
        tbl[4]  = '{0, 0, 0, 0, 0,  0,    0,    1, 0, 0, 1, SUB};
        tbl[5]  = '{0, 1, 1, 0, 16, BEQ,  ADD2, 0, 0, 0, 0, 0};
        tbl[6]  = '{0, 0, 0, 0, 0,  0,    0,    1, 0, 1, 2, BEQ};
        tbl[7]  = '{0, 0, 0, 0, 0,  0,    0,    1, 0, 0, 1, ADD2};
        tbl[8]  = '{0, 1, 1, 0, 24, ADD1, SUB,  0, 0, 0, 0, 0};
        tbl[9]  = '{0, 0, 0, 0, 0,  0,    0,    1, 0, 1, 2, ADD1};
        tbl[10] = '{0, 0, 0, 0, 0,  0,    0,    1, 0, 0, 1, SUB};
        tbl[11] = '{0, 0, 0, 0, 0,  0,    0,    0, 0, 0, 0, 0};

        dq_rst       = 1'b0;
        dq_i_flush   = 1'b0;
        dq_i_valid_1 = 1'b0;
        dq_i_valid_2 = 1'b0;
        dq_i_stall   = 1'b0;
        dq_i_pc_1    = '0;
        dq_i_pc_2    = '0;
        dq_i_instr_1 = '0;
        dq_i_instr_2 = '0;
        repeat (2) @(posedge dq_clk);
        @(negedge dq_clk);
        chk("rst_count", 64'(dq_o_count), 64'd0);
        chk("rst_ready", 64'(dq_o_ready), 64'd1);
        chk("rst_valid_1", 64'(dq_o_valid_1), 64'd0);
        chk("rst_valid_2", 64'(dq_o_valid_2), 64'd0);
        chk("rst_single", 64'(dq_o_single), 64'd0);
        chk("rst_instr_1", 64'(dq_o_instr_1), 64'd0);
        dq_rst = 1'b1;

        for (int i = 0; i < 12; i++) begin
            drive(tbl[i].fl, tbl[i].v1, tbl[i].v2, tbl[i].st,
                  tbl[i].pc, tbl[i].i1, tbl[i].i2);
            chk($sformatf("row%0d_v1", i), 64'(dq_o_valid_1), 64'(tbl[i].ev1));
            chk($sformatf("row%0d_v2", i), 64'(dq_o_valid_2), 64'(tbl[i].ev2));
            chk($sformatf("row%0d_single", i), 64'(dq_o_single), 64'(tbl[i].es));
            chk($sformatf("row%0d_count", i), 64'(dq_o_count), 64'(tbl[i].ec));
            chk($sformatf("row%0d_instr_1", i), 64'(dq_o_instr_1),
                64'(tbl[i].eo1));
            model_check();
            tick();
        end
`ifdef DIQ_STALL_CNT_EN
        drive(0, 0, 0, 0, 0, 0, 0);
        chk("single_cnt_3", 64'(dq_o_single_cnt), 64'd3);
        model_check();
        tick();
`endif

        // Shift the pointers to 3 so the full-queue drain straddles entry 7 -> 0.
        step(0, 1, 1, 0, 200, sw_ins(20), sw_ins(21));
        step(0, 1, 0, 0, 208, sw_ins(22), 0);
        step(0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);

        for (int k = 0; k < 3; k++)
            step(0, 1, 1, 1, `PC_WIDTH'(300 + 8 * k), sw_ins(2 * k),
                 sw_ins(2 * k + 1));
        step(0, 1, 0, 1, 324, sw_ins(6), 0);
        drive(0, 1, 1, 1, 400, sw_ins(9), sw_ins(9));
        chk("full_ready", 64'(dq_o_ready), 64'd0);
        chk("full_count", 64'(dq_o_count), 64'd7);
        model_check();
        tick();
        for (int k = 0; k < 4; k++) begin
            drive(0, 0, 0, 0, 0, 0, 0);
            chk("drain_count", 64'(dq_o_count), 64'(7 - 2 * k));
            model_check();
            tick();
        end
        drive(0, 0, 0, 0, 0, 0, 0);
        chk("drained_v1", 64'(dq_o_valid_1), 64'd0);
        model_check();
        tick();

        step(0, 1, 1, 1, 500, sw_ins(1), sw_ins(2));
        step(0, 1, 1, 1, 508, ADD1, SUB);
        step(0, 1, 0, 1, 516, sw_ins(3), 0);
        drive(1, 1, 1, 0, 600, sw_ins(4), sw_ins(5));
        chk("preflush_count", 64'(dq_o_count), 64'd5);
        model_check();
        tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        chk("flush_count", 64'(dq_o_count), 64'd0);
        chk("flush_v1", 64'(dq_o_valid_1), 64'd0);
        model_check();
        tick();

        step(0, 1, 1, 1, 700, sw_ins(7), sw_ins(8));
        step(0, 1, 1, 1, 708, ADD1, SUB);
        @(negedge dq_clk);
        dq_i_valid_1 = 1'b0;
        dq_i_valid_2 = 1'b0;
        dq_i_stall   = 1'b0;
        #2;
        dq_rst = 1'b0;
        #1;
        chk("mid_rst_count", 64'(dq_o_count), 64'd0);
        chk("mid_rst_ready", 64'(dq_o_ready), 64'd1);
        chk("mid_rst_v1", 64'(dq_o_valid_1), 64'd0);
        chk("mid_rst_v2", 64'(dq_o_valid_2), 64'd0);
        chk("mid_rst_single", 64'(dq_o_single), 64'd0);
        chk("mid_rst_pc_1", 64'(dq_o_pc_1), 64'd0);
        q.delete();
        mcnt = 0;
        @(posedge dq_clk);
        @(negedge dq_clk);
        dq_rst = 1'b1;

        for (int c = 0; c < 400; c++) begin
            logic a;
            logic b;
            a = ($urandom_range(9) < 7);
            b = a && ($urandom_range(1) == 1);
            step(($urandom_range(31) == 0), a, b, ($urandom_range(3) == 0),
                 `PC_WIDTH'($urandom), rnd_ins(), rnd_ins());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
